// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding and width helpers for the data-cache sequencer
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_e;

  // A counter that only ever holds 0..n-1 needs clog2(n) bits, but never fewer than one.
  function automatic int lat_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

  function automatic int word_w(input int bw);
    return (bw <= 2) ? 1 : $clog2(bw);
  endfunction

endpackage

// File: rtl/cache_ctrl_timer.sv
// rtl/cache_ctrl_timer.sv - loadable down-counter with zero flag for main-memory latency
module cache_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-through no-write-allocate D-cache sequencer; CACHE_CTRL_STATS_EN adds read hit/miss counters
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Mem_Read,
  input  logic                            Mem_Write,
  input  logic                            hit,
  output logic                            stall,
  output logic                            mm_rd_en,
  output logic                            mm_wr_en,
  output logic [word_w(BLOCK_WORDS)-1:0]  refill_word,
  output logic                            cache_we,
  output logic                            data_sel,
`ifdef CACHE_CTRL_STATS_EN
  output logic [31:0]                     read_hits,
  output logic [31:0]                     read_misses,
`endif
  output logic                            tag_we
);

  localparam int LAT_W  = lat_w(MEM_LATENCY);
  localparam int WORD_W = word_w(BLOCK_WORDS);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

  if (DATA_WIDTH < 1 || MEM_LATENCY < 1 || BLOCK_WORDS < 1) begin : g_bad_cfg
    $error("cache_controller: invalid parameters");
  end

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                tmr_load, tmr_dec, tmr_zero;

  cache_ctrl_timer #(.W(LAT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LAT_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    stall       = 1'b0;
    mm_rd_en    = 1'b0;
    mm_wr_en    = 1'b0;
    cache_we    = 1'b0;
    data_sel    = 1'b0;
    tag_we      = 1'b0;
    refill_word = word_q;
    unique case (state_q)
      IDLE: begin
        stall = Mem_Write | (Mem_Read & ~hit);
        // Stores win over a simultaneous load; the hit word is updated in place.
        if (Mem_Write) begin
          cache_we = hit;
          state_d  = WRITE;
          tmr_load = 1'b1;
        end else if (Mem_Read && !hit) begin
          state_d  = REFILL;
          tmr_load = 1'b1;
          word_d   = '0;
        end
      end
      WRITE: begin
        stall    = 1'b1;
        mm_wr_en = 1'b1;
        if (tmr_zero) begin
          state_d = DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mm_rd_en = 1'b1;
        if (tmr_zero) begin
          cache_we = 1'b1;
          data_sel = 1'b1;
          // Tag goes valid only once the whole block has landed.
          if (word_q == LAST_WORD) begin
            tag_we  = 1'b1;
            state_d = DONE;
          end else begin
            word_d   = word_q + 1'b1;
            tmr_load = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] read_hits_q, read_hits_d;
  logic [31:0] read_misses_q, read_misses_d;
  logic        rd_accept;

  assign rd_accept = (state_q == IDLE) && Mem_Read && !Mem_Write;

  always_comb begin
    read_hits_d   = read_hits_q;
    read_misses_d = read_misses_q;
    if (rd_accept && hit && (read_hits_q != '1)) begin
      read_hits_d = read_hits_q + 32'd1;
    end
    if (rd_accept && !hit && (read_misses_q != '1)) begin
      read_misses_d = read_misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_hits_q   <= '0;
      read_misses_q <= '0;
    end else begin
      read_hits_q   <= read_hits_d;
      read_misses_q <= read_misses_d;
    end
  end

  assign read_hits   = read_hits_q;
  assign read_misses = read_misses_q;
`endif

endmodule
